// File: rtl/writeback_pkg.sv
// Shared constants for the writeback stage: ALU opcodes and default sizes.
// Optional feature macro: WRITEBACK_BYPASS_EN (same-edge write-to-read bypass).
package writeback_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREG  = 3;
    localparam int DEF_NOPER = 3;

    localparam logic [DEF_NOPER-1:0] OP_AND  = 3'd0;
    localparam logic [DEF_NOPER-1:0] OP_OR   = 3'd1;
    localparam logic [DEF_NOPER-1:0] OP_ADD  = 3'd2;
    localparam logic [DEF_NOPER-1:0] OP_SUB  = 3'd3;
    localparam logic [DEF_NOPER-1:0] OP_XOR  = 3'd4;
    localparam logic [DEF_NOPER-1:0] OP_NOT  = 3'd5;
    localparam logic [DEF_NOPER-1:0] OP_SLT  = 3'd6;
    localparam logic [DEF_NOPER-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/writeback_regfile.sv
// Register bank: 2**NREG entries, two combinational read ports, one write port.
// Entry 0 is an ordinary writable register; the whole bank clears on reset.
module writeback_regfile
    import writeback_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREG-1:0]  raddr_a,
    input  logic [NREG-1:0]  raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             we,
    input  logic [NREG-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata
);

    localparam int DEPTH = 2 ** NREG;

    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];

    // Next bank contents: only the addressed entry changes when writing.
    always_comb begin
        bank_d = bank_q;
        if (we) begin
            bank_d[waddr] = wdata;
        end
    end

    // Bank storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    assign rdata_a = bank_q[raddr_a];
    assign rdata_b = bank_q[raddr_b];

endmodule

// File: rtl/writeback_top.sv
// Execute/writeback slice: regfile reads, ALU, writeback mux, registered r_out.
// Optional feature macro: WRITEBACK_BYPASS_EN (forward same-edge write data).
module writeback_top
    import writeback_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = DEF_NREG,
    parameter int NOPER = DEF_NOPER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREG-1:0]  reg_addr1,
    input  logic [NREG-1:0]  reg_addr2,
    input  logic [NREG-1:0]  reg_addr3,
    input  logic [WIDTH-1:0] data,
    input  logic [NOPER-1:0] oper,
    input  logic             sel,
    input  logic             write_en,
    output logic [WIDTH-1:0] r_out
);

    logic [WIDTH-1:0] bank_a;
    logic [WIDTH-1:0] bank_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] r_out_d;
    logic [WIDTH-1:0] r_out_q;

    writeback_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (reg_addr1),
        .raddr_b (reg_addr2),
        .rdata_a (bank_a),
        .rdata_b (bank_b),
        .we      (write_en),
        .waddr   (reg_addr3),
        .wdata   (wb)
    );

    // Operand select; forwarding uses data directly since only sel=0 bypasses,
    // which keeps the path free of any ALU-to-operand loop.
    always_comb begin
        op_a = bank_a;
        op_b = bank_b;
`ifdef WRITEBACK_BYPASS_EN
        if (write_en && !sel && (reg_addr1 == reg_addr3)) begin
            op_a = data;
        end
        if (write_en && !sel && (reg_addr2 == reg_addr3)) begin
            op_b = data;
        end
`endif
    end

    // ALU: results truncated to WIDTH bits.
    always_comb begin
        alu_res = '0;
        case (oper)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOT:  alu_res = ~op_a;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            OP_PASS: alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    // Writeback mux feeding both the bank and the output register.
    always_comb begin
        wb      = sel ? alu_res : data;
        r_out_d = wb;
    end

    // Output register loads the writeback value every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= r_out_d;
        end
    end

    assign r_out = r_out_q;

endmodule

// File: tb/tb_writeback_top.sv
// Self-checking bench for writeback_top: directed plan steps, then random
// traffic against an arithmetic reference model of the bank and ALU.
module tb_writeback_top;

    logic       clk;
    logic       rst_n;
    logic [2:0] reg_addr1;
    logic [2:0] reg_addr2;
    logic [2:0] reg_addr3;
    logic [3:0] data;
    logic [2:0] oper;
    logic       sel;
    logic       write_en;
    logic [3:0] r_out;

    int n_assert;
    int n_fail;
    int mbank [8];
    int m_rout;

    writeback_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_addr1 (reg_addr1),
        .reg_addr2 (reg_addr2),
        .reg_addr3 (reg_addr3),
        .data      (data),
        .oper      (oper),
        .sel       (sel),
        .write_en  (write_en),
        .r_out     (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return (a + b) % 16;
            3: return (a - b + 16) % 16;
            4: return a ^ b;
            5: return 15 - a;
            6: return (a < b) ? 1 : 0;
            default: return a;
        endcase
    endfunction

    function automatic int operand(input int ra);
        int v;
        v = mbank[ra];
`ifdef WRITEBACK_BYPASS_EN
        if (write_en && !sel && ra == int'(reg_addr3)) v = int'(data);
`endif
        return v;
    endfunction

    function automatic int model_alu();
        return alu_ref(int'(oper), operand(int'(reg_addr1)),
                       operand(int'(reg_addr2)));
    endfunction

    // Drive one cycle; called just after a rising edge. lit >= 0 adds a
    // directed literal check of r_out; alu_lit >= 0 checks the ALU mid-cycle.
    task automatic step(input int a1, input int a2, input int a3, input int d,
                        input int op, input int s, input int we,
                        input string tag, input int lit = -1,
                        input int alu_lit = -1);
        int wbv;
        reg_addr1 = 3'(a1);
        reg_addr2 = 3'(a2);
        reg_addr3 = 3'(a3);
        data      = 4'(d);
        oper      = 3'(op);
        sel       = s[0];
        write_en  = we[0];
        #2;
        wbv = sel ? model_alu() : int'(data);
        if (alu_lit >= 0) check({tag, "_alu"}, dut.alu_res, 4'(alu_lit));
        @(posedge clk);
        #1;
        if (we != 0) mbank[a3] = wbv;
        m_rout = wbv;
        check(tag, r_out, 4'(m_rout));
        if (lit >= 0) check({tag, "_lit"}, r_out, 4'(lit));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbank[i] = 0;
        m_rout = 0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_reset();
        rst_n     = 1'b0;
        reg_addr1 = 3'd5;
        reg_addr2 = 3'd6;
        reg_addr3 = 3'd1;
        data      = 4'hC;
        oper      = 3'd2;
        sel       = 1'b0;
        write_en  = 1'b1;
        #3;
        check("reset_rout", r_out, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", r_out, 4'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) step(i, 0, 0, 0, 7, 1, 0, "reset_bank", 0);

        step(0, 0, 0, 4'h3, 0, 0, 1, "load0", 4'h3);
        step(0, 0, 1, 4'h5, 0, 0, 1, "load1", 4'h5);
        step(0, 0, 2, 4'hA, 0, 0, 1, "load2", 4'hA);
        step(0, 0, 3, 4'hF, 0, 0, 1, "load3", 4'hF);
        step(0, 0, 0, 0, 7, 1, 0, "read0", 4'h3);
        step(1, 0, 0, 0, 7, 1, 0, "read1", 4'h5);
        step(2, 0, 0, 0, 7, 1, 0, "read2", 4'hA);
        step(3, 0, 0, 0, 7, 1, 0, "read3", 4'hF);

        step(1, 2, 0, 0, 0, 1, 0, "op_and",  4'h0);
        step(1, 2, 0, 0, 1, 1, 0, "op_or",   4'hF);
        step(1, 2, 0, 0, 2, 1, 0, "op_add",  4'hF);
        step(1, 2, 0, 0, 3, 1, 0, "op_sub",  4'hB);
        step(1, 2, 0, 0, 4, 1, 0, "op_xor",  4'hF);
        step(1, 2, 0, 0, 5, 1, 0, "op_not",  4'hA);
        step(1, 2, 0, 0, 6, 1, 0, "op_slt",  4'h1);
        step(1, 2, 0, 0, 7, 1, 0, "op_pass", 4'h5);
        step(2, 1, 0, 0, 6, 1, 0, "op_slt0", 4'h0);

        repeat (3) step(0, 0, 2, 7, 0, 0, 0, "wr_dis", 4'h7);
        step(2, 0, 0, 0, 7, 1, 0, "wr_dis_bank", 4'hA);

        step(3, 0, 4, 0, 2, 1, 1, "alu_wb", 4'h2);
        step(4, 0, 0, 0, 7, 1, 0, "alu_wb_bank", 4'h2);

`ifdef WRITEBACK_BYPASS_EN
        step(1, 0, 1, 9, 7, 0, 1, "same_addr", 4'h9, 9);
`else
        step(1, 0, 1, 9, 7, 0, 1, "same_addr", 4'h9, 5);
`endif
        step(1, 0, 0, 0, 7, 1, 0, "same_addr_bank", 4'h9);

        for (int n = 0; n < 300; n++) begin
            if (n == 150) begin
                reg_addr3 = 3'd6;
                data      = 4'hD;
                sel       = 1'b0;
                write_en  = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                check("midreset_rout", r_out, 4'h0);
                @(posedge clk);
                #1;
                check("midreset_hold", r_out, 4'h0);
                rst_n = 1'b1;
                for (int i = 0; i < 8; i++)
                    step(i, 0, 0, 0, 7, 1, 0, "midreset_bank", 0);
            end
            step($urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 1), "random");
        end

        for (int i = 0; i < 8; i++)
            step(i, 0, 0, 0, 7, 1, 0, "final_bank");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_top.md
# writeback_top

Execute-and-writeback datapath slice: a `2**NREG`-entry register bank with two combinational read ports and one synchronous write port, a small ALU combining the two read operands, and a writeback mux that chooses between the ALU result and external `data`. It is the last stage of the teaching pipeline: the selected writeback value is stored into the bank and presented, registered, on `r_out`.

## Interface

Parameters:
- `WIDTH`, default 4: data/register width.
- `NREG`, default 3: register address width; the bank holds `2**NREG` entries.
- `NOPER`, default 3: ALU opcode width.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `reg_addr1`, input, NREG: read address, operand A.
- `reg_addr2`, input, NREG: read address, operand B.
- `reg_addr3`, input, NREG: write address.
- `data`, input, WIDTH: external writeback data.
- `oper`, input, NOPER: ALU opcode.
- `sel`, input, 1: writeback select; 0 selects `data`, 1 selects the ALU result.
- `write_en`, input, 1: write strobe.
- `r_out`, output, WIDTH: registered writeback value.

## Operation

- `A = bank[reg_addr1]` and `B = bank[reg_addr2]` are combinational reads.
- ALU result by `oper`, truncated to WIDTH bits:
  - 0: A & B
  - 1: A | B
  - 2: A + B, carry discarded
  - 3: A − B, modulo 2**WIDTH
  - 4: A ^ B
  - 5: ~A
  - 6: unsigned A < B, giving 1 or 0 zero-extended
  - 7: pass A
- `wb = sel ? alu : data`.
- On a rising edge with `write_en = 1`: `bank[reg_addr3] <= wb`. All entries are writable, including entry 0, which is not hardwired.
- `write_en = 0`: the bank is unchanged.
- Every rising edge: `r_out <= wb`, regardless of `write_en`.
- Same-edge read/write of the same address: reads return the old contents (no bypass) unless `WRITEBACK_BYPASS_EN` is defined.

## Timing

- Reset (`rst_n = 0`, asynchronous): all bank entries are 0 and `r_out = 0`. Both hold until the first rising edge after deassertion.
- Reset asserted mid-operation: clears everything immediately. A write coinciding with that edge is lost.
- Read latency: 0 cycles, combinational.
- Write latency: a value written at edge N is visible on the read ports after edge N.
- `r_out` latency: 1 cycle from the inputs.
- No handshake. `write_en` is sampled only at rising edges and may be held high across several cycles, giving one write per edge.

## Configuration

`WRITEBACK_BYPASS_EN`:
- Defined: if `write_en = 1` and `reg_addr1 == reg_addr3`, operand A is taken from `wb` instead of the bank. The same applies to B with `reg_addr2`. The loop is combinational but acyclic in practice only when `sel = 0`. With `sel = 1` and a matching address, bypass is suppressed and the old bank value is used.
- Undefined: pure bank reads.

## Structure

- Shared package `writeback_pkg` holds:
  - opcode constants `OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_NOT`, `OP_SLT`, `OP_PASS`, with values 0–7;
  - default `WIDTH`, `NREG` and `NOPER` constants.
- One sub-module, `writeback_regfile`, contains the bank with async reset, two read ports and one write port. The ALU, mux, bypass and `r_out` register live in `writeback_top`.

## Test plan

- Reset: `rst_n = 0` with arbitrary inputs -> `r_out = 0`; every address reads 0 through `oper = 7`, `sel = 1`.
- Load: `sel = 0`, `write_en = 1`, writing `data` 4'h3, 4'h5, 4'hA, 4'hF to addresses 0–3 on successive edges. Then `sel = 1`, `oper = 7`, `reg_addr1 = 0..3` -> `r_out` reads 3, 5, A, F, one cycle after each address is applied.
- ALU sweep with A = reg1 = 5 and B = reg2 = A (hex), `sel = 1`:
  - ops 0–3 -> 0, F, F, B
  - ops 4–7 -> F, A, 1, 5
- Write disabled: `write_en = 0`, `data = 7`, `reg_addr3 = 2` for several edges -> `bank[2]` is still A; `r_out = 7` with `sel = 0`.
- Writeback of the ALU result: `oper = 2`, A = F, B = 3, `sel = 1`, `write_en = 1`, `reg_addr3 = 4` -> `bank[4] = 2` (wrap).
- Same-address read/write with `reg_addr1 = reg_addr3 = 1`, `sel = 0`, `data = 9`, `write_en = 1`, `oper = 7`:
  - without `WRITEBACK_BYPASS_EN`, the ALU sees the old value 5 during that cycle;
  - with it, the ALU sees 9.
